// File: rtl/maxfinder_pkg.sv
// Shared definitions for the max-finder control unit: state encoding and default sizes.
package maxfinder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] LASTADDR  = 4'hf;
    localparam int         UPD_W_DEF = 5;

endpackage

// File: rtl/maxfinder_ctrl.sv
// Control FSM for the max-finder datapath: clears, scans 0..LASTADDR once, then holds the result until ack.
// Optional MAXFINDER_CTRL_CYCLE_CNT_EN adds cyc_cnt, the number of clocks spent in INIT+SCAN.
module maxfinder_ctrl
    import maxfinder_pkg::*;
#(
    parameter int UPD_W = UPD_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             din_gt_max,
    input  logic             addr_eq_last,
    output logic             en_addr,
    output logic             s_addr,
    output logic             en_max,
    output logic             s_max,
    output logic             busy,
    output logic             done,
`ifdef MAXFINDER_CTRL_CYCLE_CNT_EN
    output logic [7:0]       cyc_cnt,
`endif
    output logic [UPD_W-1:0] upd_cnt
);

    localparam logic [UPD_W-1:0] UPD_ONE = {{(UPD_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [UPD_W-1:0] upd_q, upd_d;

    // Datapath controls are Mealy in SCAN because en_max must follow the live compare flag.
    always_comb begin
        state_d = state_q;
        upd_d   = upd_q;
        en_addr = 1'b0;
        s_addr  = 1'b0;
        en_max  = 1'b0;
        s_max   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                upd_d = '0;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    en_addr = 1'b1;
                    en_max  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    s_max  = 1'b1;
                    en_max = din_gt_max;
                    if (din_gt_max && (upd_q != '1)) upd_d = upd_q + UPD_ONE;
                    if (addr_eq_last) begin
                        state_d = DONE;
                    end else begin
                        en_addr = 1'b1;
                        s_addr  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            upd_q   <= '0;
        end else begin
            state_q <= state_d;
            upd_q   <= upd_d;
        end
    end

    assign busy    = (state_q == INIT) || (state_q == SCAN);
    assign done    = (state_q == DONE);
    assign upd_cnt = upd_q;

`ifdef MAXFINDER_CTRL_CYCLE_CNT_EN
    logic [7:0] cyc_q, cyc_d;

    // Restarts on the IDLE->INIT edge so a reading in DONE covers only the latest scan.
    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == IDLE) && start) cyc_d = 8'd0;
        else if (busy)                  cyc_d = cyc_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= 8'd0;
        else        cyc_q <= cyc_d;
    end

    assign cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_maxfinder_ctrl.sv
// Self-checking bench for maxfinder_ctrl with a behavioural address/max datapath and 16-word memory.
// Build with MAXFINDER_CTRL_CYCLE_CNT_EN to also check cyc_cnt.
module tb_maxfinder_ctrl;
    import maxfinder_pkg::*;

    localparam int UPD_W = UPD_W_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, ack, din_gt_max, addr_eq_last;
    logic en_addr, s_addr, en_max, s_max, busy, done;
    logic [UPD_W-1:0] upd_cnt;
`ifdef MAXFINDER_CTRL_CYCLE_CNT_EN
    logic [7:0] cyc_cnt;
`endif

    logic [7:0] mem [16];
    logic [3:0] addr   = 4'h9;
    logic [7:0] maxReg = 8'haa;

    int checks = 0;
    int errors = 0;

    maxfinder_ctrl #(.UPD_W(UPD_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ack(ack),
        .din_gt_max(din_gt_max), .addr_eq_last(addr_eq_last),
        .en_addr(en_addr), .s_addr(s_addr), .en_max(en_max), .s_max(s_max),
        .busy(busy), .done(done),
`ifdef MAXFINDER_CTRL_CYCLE_CNT_EN
        .cyc_cnt(cyc_cnt),
`endif
        .upd_cnt(upd_cnt)
    );

    // Stand-in for the real datapath: registers are only ever changed through the controller's enables.
    always @(posedge clk) begin
        if (en_addr) addr <= s_addr ? addr + 4'd1 : 4'd0;
        if (en_max)  maxReg <= s_max ? mem[addr] : 8'd0;
    end
    assign din_gt_max   = mem[addr] > maxReg;
    assign addr_eq_last = (addr == LASTADDR);

    typedef struct {
        string             name;
        logic [15:0][7:0]  words;
        logic [7:0]        expMax;
        int                expUpd;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic k);
        start = s;
        abort = a;
        ack   = k;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic loadMem(input logic [15:0][7:0] w);
        for (int i = 0; i < 16; i++) mem[i] = w[i];
    endtask

    // Called at a negedge in IDLE; returns with the bench at the negedge where done is first seen.
    task automatic runScan(output int cycles, output int enMaxCnt);
        start    = 1'b1;
        cycles   = 0;
        enMaxCnt = 0;
        while (1) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (en_max) enMaxCnt++;
            if (cycles > 40) break;
        end
    endtask

    task automatic waitAddr(input logic [3:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && addr == a) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [15:0][7:0] ascending;
    logic [15:0][7:0] zeros;

    initial begin
        int cycles, enMaxCnt;
        bit ok, saw;
        int pat0 [6] = '{3, 7, 2, 9, 9, 1};

        for (int i = 0; i < 16; i++) begin
            ascending[i] = 8'(i);
            zeros[i]     = 8'd0;
        end
        vecs[0].name = "mixed";      vecs[0].expMax = 8'd9;   vecs[0].expUpd = 3;
        vecs[1].name = "allZero";    vecs[1].expMax = 8'd0;   vecs[1].expUpd = 0;
        vecs[2].name = "ascending";  vecs[2].expMax = 8'd15;  vecs[2].expUpd = 15;
        vecs[3].name = "descending"; vecs[3].expMax = 8'd15;  vecs[3].expUpd = 1;
        vecs[4].name = "allFives";   vecs[4].expMax = 8'd5;   vecs[4].expUpd = 1;
        vecs[5].name = "lastOnly";   vecs[5].expMax = 8'd200; vecs[5].expUpd = 1;
        for (int i = 0; i < 16; i++) begin
            vecs[0].words[i] = (i < 6) ? 8'(pat0[i]) : 8'd0;
            vecs[1].words[i] = 8'd0;
            vecs[2].words[i] = 8'(i);
            vecs[3].words[i] = 8'(15 - i);
            vecs[4].words[i] = 8'd5;
            vecs[5].words[i] = (i == 15) ? 8'd200 : 8'd0;
        end

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
        loadMem(zeros);
        #12;
        checkOutput("resetOutputs", {en_addr, s_addr, en_max, s_max, busy, done}, 0);
        checkOutput("resetUpdCnt", upd_cnt, 0);
`ifdef MAXFINDER_CTRL_CYCLE_CNT_EN
        checkOutput("resetCycCnt", cyc_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 6; v++) begin
            loadMem(vecs[v].words);
            runScan(cycles, enMaxCnt);
            checkOutput({vecs[v].name, ".latency"}, cycles, 18);
            checkOutput({vecs[v].name, ".max"}, maxReg, vecs[v].expMax);
            checkOutput({vecs[v].name, ".updCnt"}, upd_cnt, vecs[v].expUpd);
            checkOutput({vecs[v].name, ".addr"}, addr, 15);
            checkOutput({vecs[v].name, ".enMaxCycles"}, enMaxCnt, vecs[v].expUpd + 1);
`ifdef MAXFINDER_CTRL_CYCLE_CNT_EN
            checkOutput({vecs[v].name, ".cycCnt"}, cyc_cnt, 17);
`endif
            applyStimulus(1'b0, 1'b0, 1'b1);
            ack = 1'b0;
            checkOutput({vecs[v].name, ".idleAfterAck"}, {busy, done}, 0);
        end

        // Result must hold indefinitely while the requester withholds ack.
        loadMem(ascending);
        runScan(cycles, enMaxCnt);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("holdDone", {done, busy, en_addr, en_max}, 4'b1000);
            checkOutput("holdMax", maxReg, 15);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        ack = 1'b0;
        checkOutput("holdAckReleases", done, 0);

        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("initBusy", busy, 1);
`ifdef MAXFINDER_CTRL_CYCLE_CNT_EN
        checkOutput("cycClearedOnStart", cyc_cnt, 0);
`endif
        abort = 1'b1;
        #1;
        checkOutput("initAbortEnables", {en_addr, en_max}, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        abort = 1'b0;
        checkOutput("initAbortIdle", {busy, done}, 0);

        loadMem(ascending);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitAddr(4'd5, ok);
        checkOutput("abortReachAddr5", ok, 1);
        abort = 1'b1;
        #1;
        checkOutput("abortEnables", {en_addr, en_max}, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        abort = 1'b0;
        checkOutput("abortIdle", {busy, done}, 0);
        checkOutput("abortUpdCnt", upd_cnt, 4);
        checkOutput("abortMax", maxReg, 4);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (done || busy) saw = 1'b1;
        end
        checkOutput("abortNoDone", saw, 0);

        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitAddr(4'd15, ok);
        checkOutput("abortReachLast", ok, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        abort = 1'b0;
        checkOutput("abortLastWins", {busy, done}, 0);
        checkOutput("abortLastUpdCnt", upd_cnt, 14);
        checkOutput("abortLastMax", maxReg, 14);

        loadMem(zeros);
        runScan(cycles, enMaxCnt);
        checkOutput("doneForStartTest", done, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("startIgnoredInDone", {done, busy}, 2'b10);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        start = 1'b0;
        ack   = 1'b0;
        checkOutput("ackWinsOverStart", {done, busy}, 0);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (busy) saw = 1'b1;
        end
        checkOutput("noRescanAfterAck", saw, 0);

        loadMem(ascending);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitAddr(4'd7, ok);
        checkOutput("resetReachAddr7", ok, 1);
        checkOutput("preResetUpdCnt", upd_cnt, 6);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetOutputs", {en_addr, s_addr, en_max, s_max, busy, done}, 0);
        checkOutput("asyncResetUpdCnt", upd_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idleAfterReset", {busy, done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
